// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and default sizing for the result-broadcast arbiter.
// The CDB_RR_EN macro selects round-robin (defined) or fixed-priority scanning.
package cdb_arbiter_pkg;

    localparam int NUM_SOURCES       = 4;
    localparam int NUM_CDB_ENTRIES   = 2;
    localparam int RO_BUFFER_ENTRIES = 8;
    localparam int CDB_TAG_W         = $clog2(RO_BUFFER_ENTRIES);

    typedef struct packed {
        logic                 valid;
        logic [CDB_TAG_W-1:0] tag;
        logic [31:0]          value;
    } cdb_entry_t;

    typedef cdb_entry_t [NUM_CDB_ENTRIES-1:0] cdb_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/cdb_pick.sv
// Combinational grant selection: scans requests from a start index and hands
// the first CDB_WIDTH requesters to slots 0..CDB_WIDTH-1 in scan order.
module cdb_pick
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int CDB_WIDTH = 2,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [IDX_W-1:0]           start,
    output logic [NUM_SRC-1:0]         grant,
    output logic [CDB_WIDTH-1:0]       slot_valid,
    output logic [CDB_WIDTH*IDX_W-1:0] slot_src
);

    always_comb begin
        int idx;
        int cnt;
        grant      = '0;
        slot_valid = '0;
        slot_src   = '0;
        idx        = int'(start);
        cnt        = 0;
        for (int j = 0; j < NUM_SRC; j++) begin
            // Loops over constant ranges keep every select index a constant.
            for (int s = 0; s < NUM_SRC; s++) begin
                if (s == idx && req[s] && cnt < CDB_WIDTH) begin
                    grant[s] = 1'b1;
                    for (int k = 0; k < CDB_WIDTH; k++) begin
                        if (k == cnt) begin
                            slot_valid[k]              = 1'b1;
                            slot_src[k*IDX_W +: IDX_W] = IDX_W'(s);
                        end
                    end
                    cnt = cnt + 1;
                end
            end
            idx = wrap_inc(idx, NUM_SRC);
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants up to CDB_WIDTH completed results per cycle
// and broadcasts them registered one cycle later. CDB_RR_EN enables round-robin.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int NUM_SRC     = NUM_SOURCES,
    parameter  int CDB_WIDTH   = NUM_CDB_ENTRIES,
    parameter  int ROB_ENTRIES = RO_BUFFER_ENTRIES,
    localparam int TAG_W       = $clog2(ROB_ENTRIES),
    localparam int IDX_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NUM_SRC-1:0]           src_valid_i,
    input  logic [NUM_SRC*TAG_W-1:0]     src_tag_i,
    input  logic [NUM_SRC*32-1:0]        src_value_i,
    output logic [NUM_SRC-1:0]           src_ready_o,
    output logic [CDB_WIDTH-1:0]         cdb_valid_o,
    output logic [CDB_WIDTH*TAG_W-1:0]   cdb_tag_o,
    output logic [CDB_WIDTH*32-1:0]      cdb_value_o
);

    logic [NUM_SRC-1:0]         grant;
    logic [CDB_WIDTH-1:0]       pick_valid;
    logic [CDB_WIDTH*IDX_W-1:0] pick_src;
    logic [IDX_W-1:0]           start;
    logic                       hold_off;

    assign hold_off = rst | flush;

`ifdef CDB_RR_EN
    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;

    // The highest occupied slot holds the last source granted in scan order.
    always_comb begin
        ptr_next = ptr_reg;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            if (pick_valid[k]) begin
                ptr_next = IDX_W'(wrap_inc(int'(pick_src[k*IDX_W +: IDX_W]), NUM_SRC));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hold_off) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign start = ptr_reg;
`else
    assign start = '0;
`endif

    cdb_pick #(
        .NUM_SRC   (NUM_SRC),
        .CDB_WIDTH (CDB_WIDTH),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req        (src_valid_i),
        .start      (start),
        .grant      (grant),
        .slot_valid (pick_valid),
        .slot_src   (pick_src)
    );

    assign src_ready_o = grant & {NUM_SRC{~hold_off}};

    genvar gi;
    generate
        for (gi = 0; gi < CDB_WIDTH; gi++) begin : g_slot
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [31:0]      value_reg;
            logic [TAG_W-1:0] tag_next;
            logic [31:0]      value_next;

            // Idle slots drive zero tag/value so no stale data lingers on the bus.
            always_comb begin
                tag_next   = '0;
                value_next = '0;
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (pick_valid[gi] && pick_src[gi*IDX_W +: IDX_W] == IDX_W'(s)) begin
                        tag_next   = src_tag_i[s*TAG_W +: TAG_W];
                        value_next = src_value_i[s*32 +: 32];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (hold_off) begin
                    valid_reg <= 1'b0;
                    tag_reg   <= '0;
                    value_reg <= '0;
                end else begin
                    valid_reg <= pick_valid[gi];
                    tag_reg   <= tag_next;
                    value_reg <= value_next;
                end
            end

            assign cdb_valid_o[gi]                = valid_reg;
            assign cdb_tag_o[gi*TAG_W +: TAG_W]   = tag_reg;
            assign cdb_value_o[gi*32 +: 32]       = value_reg;
        end
    endgenerate

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a 4-source/2-slot instance plus a
// 4-source/1-slot instance for the fairness sequence.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  src_valid;
    logic [11:0] src_tag;
    logic [127:0] src_value;
    logic [3:0]  src_ready;
    logic [1:0]  cdb_valid;
    logic [5:0]  cdb_tag;
    logic [63:0] cdb_value;

    logic [3:0]  src1_valid;
    logic [11:0] src1_tag;
    logic [127:0] src1_value;
    logic [3:0]  src1_ready;
    logic [0:0]  cdb1_valid;
    logic [2:0]  cdb1_tag;
    logic [31:0] cdb1_value;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_SRC(4), .CDB_WIDTH(2), .ROB_ENTRIES(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid_i(src_valid), .src_tag_i(src_tag), .src_value_i(src_value),
        .src_ready_o(src_ready),
        .cdb_valid_o(cdb_valid), .cdb_tag_o(cdb_tag), .cdb_value_o(cdb_value)
    );

    cdb_arbiter #(.NUM_SRC(4), .CDB_WIDTH(1), .ROB_ENTRIES(8)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid_i(src1_valid), .src_tag_i(src1_tag), .src_value_i(src1_value),
        .src_ready_o(src1_ready),
        .cdb_valid_o(cdb1_valid), .cdb_tag_o(cdb1_tag), .cdb_value_o(cdb1_value)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [2:0] t, input logic [31:0] v);
        src_tag[i*3 +: 3]    = t;
        src_value[i*32 +: 32] = v;
    endtask

    task automatic check_cdb(input string name, input logic [1:0] v,
                             input logic [2:0] t0, input logic [31:0] v0,
                             input logic [2:0] t1, input logic [31:0] v1);
        check({name, "_valid"}, 64'(cdb_valid), 64'(v));
        check({name, "_tag0"},  64'(cdb_tag[2:0]), 64'(t0));
        check({name, "_val0"},  64'(cdb_value[31:0]), 64'(v0));
        check({name, "_tag1"},  64'(cdb_tag[5:3]), 64'(t1));
        check({name, "_val1"},  64'(cdb_value[63:32]), 64'(v1));
    endtask

    initial begin
        logic [3:0]  fair_exp [4];
        logic [31:0] v0;
        logic [31:0] v3;
        logic        wake;
`ifdef CDB_RR_EN
        fair_exp = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
`else
        fair_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        rst = 1'b1; flush = 1'b0;
        src_valid = 4'b1111; src_tag = '0; src_value = '0;
        src1_valid = 4'b0000; src1_tag = '0; src1_value = '0;
        for (int i = 0; i < 4; i++) set_src(i, 3'(4 + i), 32'h100 + 32'(i));

        // Reset held two cycles with every source requesting.
        #1;
        @(negedge clk);
        check("rst_ready_c0", 64'(src_ready), 64'h0);
        check("rst_cdb_c0", 64'(cdb_valid), 64'h0);
        cyc();
        @(negedge clk);
        check("rst_ready_c1", 64'(src_ready), 64'h0);
        check("rst_cdb_c1", 64'(cdb_valid), 64'h0);
        cyc();
        rst = 1'b0;

        // Oversubscription from ptr=0: src0/1 then src2/3.
        @(negedge clk);
        check("over_ready_c0", 64'(src_ready), 64'b0011);
        cyc();
        src_valid = 4'b1100;
        check_cdb("over_c0", 2'b11, 3'd4, 32'h100, 3'd5, 32'h101);
        @(negedge clk);
        check("over_ready_c1", 64'(src_ready), 64'b1100);
        cyc();
        src_valid = 4'b0000;
        check_cdb("over_c1", 2'b11, 3'd6, 32'h102, 3'd7, 32'h103);
        @(negedge clk);
        check("over_ready_c2", 64'(src_ready), 64'h0);
        cyc();
        check("over_once", 64'(cdb_valid), 64'h0);

        // Single requester lands in slot 0, slot 1 idle and zeroed.
        set_src(2, 3'd3, 32'hDEADBEEF);
        src_valid = 4'b0100;
        @(negedge clk);
        check("single_ready", 64'(src_ready), 64'b0100);
        cyc();
        src_valid = 4'b0000;
        check_cdb("single", 2'b01, 3'd3, 32'hDEADBEEF, 3'd0, 32'h0);

        // Flush cycle: no grant, no broadcast; then normal grant.
        set_src(1, 3'd2, 32'h11);
        src_valid = 4'b0010;
        flush = 1'b1;
        @(negedge clk);
        check("flush_ready", 64'(src_ready), 64'h0);
        cyc();
        flush = 1'b0;
        check("flush_cdb", 64'(cdb_valid), 64'h0);
        @(negedge clk);
        check("post_flush_ready", 64'(src_ready), 64'b0010);
        cyc();
        src_valid = 4'b0000;
        check_cdb("post_flush", 2'b01, 3'd2, 32'h11, 3'd0, 32'h0);

        // Flush while a broadcast is on the bus clears it the next cycle.
        set_src(3, 3'd1, 32'h33);
        src_valid = 4'b1000;
        cyc();
        src_valid = 4'b0000;
        flush = 1'b1;
        check_cdb("pre_midflush", 2'b01, 3'd1, 32'h33, 3'd0, 32'h0);
        cyc();
        flush = 1'b0;
        check_cdb("midflush", 2'b00, 3'd0, 32'h0, 3'd0, 32'h0);

        // Tag 0 qualification: idle slot must not wake a tag-0 waiter.
        wake = cdb_valid[0] && (cdb_tag[2:0] == 3'd0);
        check("tag0_nowake", 64'(wake), 64'h0);
        set_src(0, 3'd0, 32'd5);
        src_valid = 4'b0001;
        @(negedge clk);
        check("tag0_ready", 64'(src_ready), 64'b0001);
        cyc();
        src_valid = 4'b0000;
        check_cdb("tag0", 2'b01, 3'd0, 32'd5, 3'd0, 32'h0);
        wake = cdb_valid[0] && (cdb_tag[2:0] == 3'd0);
        check("tag0_wake", 64'(wake), 64'h1);

        // Fairness on the single-slot instance, src0 and src3 always requesting.
        v0 = 32'hA000; v3 = 32'hB000;
        src1_tag = '0;
        src1_tag[2:0]  = 3'd1;
        src1_tag[11:9] = 3'd6;
        src1_valid = 4'b1001;
        for (int n = 0; n < 4; n++) begin
            src1_value[31:0]   = v0;
            src1_value[127:96] = v3;
            @(negedge clk);
            check($sformatf("fair_ready_%0d", n), 64'(src1_ready), 64'(fair_exp[n]));
            cyc();
            check($sformatf("fair_valid_%0d", n), 64'(cdb1_valid), 64'h1);
            if (fair_exp[n] == 4'b0001) begin
                check($sformatf("fair_tag_%0d", n), 64'(cdb1_tag), 64'd1);
                check($sformatf("fair_val_%0d", n), 64'(cdb1_value), 64'(v0));
                v0 = v0 + 1;
            end else begin
                check($sformatf("fair_tag_%0d", n), 64'(cdb1_tag), 64'd6);
                check($sformatf("fair_val_%0d", n), 64'(cdb1_value), 64'(v3));
                v3 = v3 + 1;
            end
        end
        src1_valid = 4'b0000;
        cyc();
        check("fair_idle", 64'(cdb1_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
